// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI message serializer with running status, 8N1 UART frames
module midi_tx #(
    parameter int CLK_FREQ       = 100000000,
    parameter int BAUD           = 31250,
    parameter int RUNNING_STATUS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [6:0] msg_data1,
    input  logic [6:0] msg_data2,
    output logic       midi_out,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam bit RS_EN = (RUNNING_STATUS != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;

    // arm is low after reset and for the single cycle following any acceptance
    logic             arm;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [1:0]       byte_idx;
    logic [1:0]       last_idx;
    logic [7:0]       status_q;
    logic [6:0]       data1_q;
    logic [6:0]       data2_q;
    logic [7:0]       rs_q;
    logic             rs_valid;

    logic             accept;
    logic             status_ok;
    logic             is_channel;
    logic             skip_status;
    logic [1:0]       msg_len;
    logic             bit_done;
    logic             last_bit;
    logic             last_byte;
    logic [7:0]       cur_byte;

    assign accept      = msg_valid & msg_ready;
    assign status_ok   = msg_status[7];
    assign is_channel  = (msg_status[7:4] != 4'hF);
    assign skip_status = RS_EN && is_channel && rs_valid && (rs_q == msg_status);
    assign bit_done    = (baud_cnt == '0);
    assign last_bit    = (bit_cnt == 3'd7);
    assign last_byte   = (byte_idx == last_idx);

    // Total message length in bytes, decoded from the status byte
    always_comb begin
        msg_len = 2'd1;
        case (msg_status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: msg_len = 2'd3;
            4'hC, 4'hD:                   msg_len = 2'd2;
            4'hF: begin
                case (msg_status[3:0])
                    4'h2:       msg_len = 2'd3;
                    4'h1, 4'h3: msg_len = 2'd2;
                    default:    msg_len = 2'd1;
                endcase
            end
            default:                      msg_len = 2'd1;
        endcase
    end

    // Byte currently on the wire: status or one of the zero-padded data bytes
    always_comb begin
        cur_byte = status_q;
        case (byte_idx)
            2'd0:    cur_byte = status_q;
            2'd1:    cur_byte = {1'b0, data1_q};
            default: cur_byte = {1'b0, data2_q};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state: start -> 8 data bits -> stop, repeated per byte
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept && status_ok) next_state = S_START;
            S_START: if (bit_done) next_state = S_DATA;
            S_DATA:  if (bit_done && last_bit) next_state = S_STOP;
            S_STOP:  if (bit_done) next_state = last_byte ? S_IDLE : S_START;
            default: next_state = S_IDLE;
        endcase
    end

    // FSM outputs: line level, handshake and busy flag
    always_comb begin
        msg_ready = 1'b0;
        busy      = 1'b1;
        midi_out  = 1'b1;
        case (state)
            S_IDLE: begin
                msg_ready = arm;
                busy      = 1'b0;
                midi_out  = 1'b1;
            end
            S_START: midi_out = 1'b0;
            S_DATA:  midi_out = cur_byte[bit_cnt];
            S_STOP:  midi_out = 1'b1;
            default: midi_out = 1'b1;
        endcase
    end

    // Datapath: message latch, running status, baud/bit/byte counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm      <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
            last_idx <= 2'd0;
            status_q <= 8'h00;
            data1_q  <= 7'h00;
            data2_q  <= 7'h00;
            rs_q     <= 8'h00;
            rs_valid <= 1'b0;
        end else begin
            arm <= ~accept;
            if (accept) begin
                // acceptance opens a fresh start-bit period, so no drift
                baud_cnt <= CNT_LOAD;
                bit_cnt  <= 3'd0;
                if (status_ok) begin
                    status_q <= msg_status;
                    data1_q  <= msg_data1;
                    data2_q  <= msg_data2;
                    byte_idx <= skip_status ? 2'd1 : 2'd0;
                    last_idx <= msg_len - 2'd1;
                    if (is_channel) begin
                        rs_q     <= msg_status;
                        rs_valid <= 1'b1;
                    end else if (!msg_status[3]) begin
                        // system common / sysex cancels running status, realtime does not
                        rs_valid <= 1'b0;
                    end
                end
            end else if (state != S_IDLE) begin
                baud_cnt <= bit_done ? CNT_LOAD : baud_cnt - 1'b1;
                if (bit_done) begin
                    if (state == S_DATA) begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    if (state == S_STOP && !last_byte) begin
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
            end
        end
    end

endmodule
